rand_pool_reader: RTL and testbench
===================================

RAND_POOL_READER -- requirements
Module: rand_pool_reader

Interface
REQ-001 Parameter DEPTH, default 8, byte FIFO depth; power of two, minimum 4.
REQ-002 Parameter REP_LIMIT, default 4, consecutive-identical-byte count that trips the health test.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 enable  input  1  high = incoming bytes accepted; low = incoming bytes ignored.
REQ-006 byte_ready  input  1  one-cycle strobe from the bit collector marking a new byte.
REQ-007 rand_byte  input  8  byte from the bit collector; valid only while byte_ready=1.
REQ-008 req  input  1  consumer requests one 32-bit word; level-sensitive, sampled in IDLE.
REQ-009 word_ack  input  1  consumer accepts the presented word.
REQ-010 word_valid  output  1  rand_word holds a complete word.
REQ-011 rand_word  output  32  assembled random word.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky: a qualified byte was dropped because the FIFO was full.
REQ-014 health_fail  output  1  sticky repetition-test failure; constant 0 when the health feature is compiled out.

Function
REQ-015 Qualified push = byte_ready & enable & ~health_fail; the byte enters the FIFO at that edge, and level reflects it one cycle after the strobe.
REQ-016 FIFO full check uses the occupancy before the edge, with a same-cycle pop counted: push while full with no pop is dropped and overflow sets; push while full with a same-cycle pop is accepted.
REQ-017 Simultaneous push and pop leave level unchanged; FIFO pointers wrap modulo DEPTH.
REQ-018 FSM states are IDLE, GATHER and PRESENT.
REQ-019 IDLE: when req=1, the FSM clears the byte counter and the word shift register and moves to GATHER on the next edge.
REQ-020 GATHER: each cycle with level>0 pops one byte and shifts it in: rand_word <= {rand_word[23:0], byte}, so the first byte popped lands in [31:24].
REQ-021 GATHER with an empty FIFO stalls; no pop occurs and the counter holds.
REQ-022 After the 4th pop the FSM enters PRESENT; minimum latency from req sampled in IDLE to word_valid=1 is 5 cycles.
REQ-023 PRESENT: word_valid=1 and rand_word is held stable until word_ack=1; on that edge the FSM returns to IDLE and word_valid=0 the next cycle.
REQ-024 word_ack outside PRESENT is ignored; req outside IDLE is ignored.
REQ-025 Deasserting req during GATHER does not abort assembly.
REQ-026 enable=0 blocks pushes only; pops, the FSM and PRESENT continue normally.

Reset
REQ-027 With rst=1 at an edge, the following are cleared: FIFO pointers, level=0, state=IDLE, word_valid=0, rand_word=0, overflow=0, health_fail=0, repetition counter=0 and last-byte register=0.
REQ-028 Reset mid-GATHER or mid-PRESENT discards any partial or presented word; no word_valid pulse follows the reset.
REQ-029 While rst=1, byte_ready is ignored.

Configuration
REQ-030 Macro RAND_POOL_HEALTH_EN: when defined, the repetition test is compiled in.
REQ-031 The repetition test compares every byte with byte_ready&enable against the last-byte register; equal increments the run counter, unequal reloads it to 1.
REQ-032 When the run reaches REP_LIMIT, the triggering byte is not pushed, health_fail sets, the FIFO is flushed (level=0), and all pushes are blocked until reset.
REQ-033 If the trip occurs during GATHER, the FSM stalls; if it occurs during PRESENT, the held word is still delivered.
REQ-034 Without RAND_POOL_HEALTH_EN: no counter or compare logic exists, health_fail is tied to 0, and REQ-015 reduces to byte_ready & enable.

Verification
REQ-035 Push 0x11,0x22,0x33,0x44, then pulse req -> word_valid=1 five cycles after req, rand_word=0x11223344, held until word_ack; level returns to 0.
REQ-036 Hold req=1 with the FIFO empty, then push 0xA0..0xA3 one per 3 cycles -> word_valid one cycle after the 4th pop, rand_word=0xA0A1A2A3, no early word_valid.
REQ-037 Fill 8 bytes, then push a 9th (0xFF) -> overflow=1, level=8; a push coincident with a GATHER pop is accepted with level unchanged.
REQ-038 Assert rst during GATHER after 2 pops -> level=0, word_valid=0, state IDLE; a fresh req plus 4 new bytes yields the correct word.
REQ-039 RAND_POOL_HEALTH_EN defined: push 0x5A four times -> health_fail=1, level=0, later bytes ignored; with the macro undefined, the same stimulus leaves level=4 and health_fail=0.
REQ-040 enable=0 while pushing 0x01..0x04 -> level stays 0 and no overflow; a word already in PRESENT is still acknowledged normally.

Source files
------------

// File: rtl/rand_pool_reader.sv
// rand_pool_reader: byte FIFO that feeds a 32-bit word assembler.
// Define RAND_POOL_HEALTH_EN to compile in the repetition health test.
module rand_pool_reader #(
  parameter int DEPTH     = 8,
  parameter int REP_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   byte_ready,
  input  logic [7:0]             rand_byte,
  input  logic                   req,
  input  logic                   word_ack,
  output logic                   word_valid,
  output logic [31:0]            rand_word,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   health_fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    PRESENT
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic [2:0]    cnt_q;
  logic [31:0]   word_q;
  logic          wv_q;

  logic strobe;
  logic trip;
  logic push;
  logic pop;
  logic accept;

  assign strobe = byte_ready & enable;

  // A pop happens only while gathering, short of a full word, with data present.
  assign pop = (state_q == GATHER) && (cnt_q != 3'd4) && (level_q != '0);

  // Full is judged on pre-edge occupancy; a same-cycle pop frees a slot.
  assign accept = push && ((level_q != LW'(DEPTH)) || pop);

`ifdef RAND_POOL_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [7:0]    last_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;
  logic          hf_q;

  // Run length including the current byte; saturates at the limit.
  always_comb begin
    run_d = RW'(1);
    if (rand_byte == last_q) begin
      run_d = (run_q == RW'(REP_LIMIT)) ? run_q : run_q + 1'b1;
    end
  end

  assign trip        = strobe & ~hf_q & (run_d == RW'(REP_LIMIT));
  assign push        = strobe & ~hf_q & ~trip;
  assign health_fail = hf_q;

  // Repetition tracker; failure is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      run_q  <= '0;
      hf_q   <= 1'b0;
    end else if (strobe) begin
      last_q <= rand_byte;
      run_q  <= run_d;
      if (trip) hf_q <= 1'b1;
    end
  end
`else
  assign trip        = 1'b0;
  assign push        = strobe;
  assign health_fail = 1'b0;
`endif

  // Byte storage; no reset needed, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_q] <= rand_byte;
  end

  // FIFO pointers, occupancy and sticky overflow; a health trip flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (trip) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      unique case ({accept, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (push && !accept) ovf_q <= 1'b1;
    end
  end

  // Word assembly FSM: wait for req, gather four bytes, hold until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cnt_q   <= '0;
            word_q  <= '0;
            state_q <= GATHER;
          end
        end
        GATHER: begin
          if (cnt_q == 3'd4) begin
            state_q <= PRESENT;
            wv_q    <= 1'b1;
          end else if (pop) begin
            word_q <= {word_q[23:0], mem_q[rd_q]};
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        PRESENT: begin
          if (word_ack) begin
            state_q <= IDLE;
            wv_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_valid = wv_q;
  assign rand_word  = word_q;
  assign level      = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rand_pool_reader.sv
// tb_rand_pool_reader: directed and random checks of rand_pool_reader
// against a queue-based reference model.
module tb_rand_pool_reader;

  localparam int DEPTH = 8;
  localparam int REP   = 4;
`ifdef RAND_POOL_HEALTH_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif
  localparam logic [31:0] EXP39_L  = HEN ? 32'd0 : 32'd4;
  localparam logic [31:0] EXP39_H  = HEN ? 32'd1 : 32'd0;
  localparam logic [31:0] EXP39_L2 = HEN ? 32'd0 : 32'd5;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        byte_ready;
  logic [7:0]  rand_byte;
  logic        req;
  logic        word_ack;
  logic        word_valid;
  logic [31:0] rand_word;
  logic [3:0]  level;
  logic        overflow;
  logic        health_fail;

  int checks = 0;
  int errors = 0;

  rand_pool_reader #(.DEPTH(DEPTH), .REP_LIMIT(REP)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .byte_ready (byte_ready),
    .rand_byte  (rand_byte),
    .req        (req),
    .word_ack   (word_ack),
    .word_valid (word_valid),
    .rand_word  (rand_word),
    .level      (level),
    .overflow   (overflow),
    .health_fail(health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents, bytes gathered so far, phase.
  byte unsigned bq[$];
  byte unsigned got[$];
  int           ph;
  bit           m_wv, m_ov, m_hf;
  byte unsigned m_last;
  int           m_run;

  function automatic logic [31:0] mword();
    logic [31:0] w;
    w = 0;
    foreach (got[i]) w = w * 256 + 32'(got[i]);
    return w;
  endfunction

  task automatic mstep();
    bit st, tr, pp, pu;
    if (rst) begin
      bq.delete(); got.delete();
      ph = 0; m_wv = 0; m_ov = 0; m_hf = 0; m_last = 0; m_run = 0;
      return;
    end
    st = byte_ready && enable;
    tr = 0;
    if (HEN && st) begin
      if (rand_byte == m_last) m_run++;
      else m_run = 1;
      m_last = rand_byte;
      tr = (m_run >= REP) && !m_hf;
    end
    pp = (ph == 1) && (got.size() < 4) && (bq.size() > 0);
    pu = st && !m_hf && !tr;
    case (ph)
      0: if (req) begin got.delete(); ph = 1; end
      1: begin
        if (got.size() == 4) begin ph = 2; m_wv = 1; end
        else if (pp) got.push_back(bq[0]);
      end
      default: if (word_ack) begin ph = 0; m_wv = 0; end
    endcase
    if (pp) void'(bq.pop_front());
    if (pu) begin
      if (bq.size() < DEPTH) bq.push_back(rand_byte);
      else m_ov = 1;
    end
    if (tr) begin bq.delete(); m_hf = 1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    mstep();
    #1;
    chk("level", 32'(level), 32'(bq.size()));
    chk("word_valid", 32'(word_valid), 32'(m_wv));
    chk("rand_word", rand_word, mword());
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
  endtask

  task automatic push1(input logic [7:0] b);
    byte_ready = 1'b1;
    rand_byte  = b;
    cyc();
    byte_ready = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_wv(output int n);
    n = 0;
    while (word_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic ack1();
    word_ack = 1'b1;
    cyc();
    word_ack = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; enable = 1'b1; byte_ready = 1'b1; rand_byte = 8'h77;
    req = 1'b0; word_ack = 1'b0;
    // Strobes during reset must be ignored.
    cyc(); cyc();
    rst = 1'b0; byte_ready = 1'b0;
    chk("rst_level", 32'(level), 0);
    chk("rst_wv", 32'(word_valid), 0);
    chk("rst_word", rand_word, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_hf", 32'(health_fail), 0);

    // Basic word, latency and hold.
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    req = 1'b1; cyc(); req = 1'b0;
    wait_wv(n);
    chk("lat_basic", n, 5);
    chk("word_basic", rand_word, 32'h11223344);
    repeat (3) cyc();
    chk("word_held", rand_word, 32'h11223344);
    ack1();
    chk("ack_wv", 32'(word_valid), 0);
    chk("ack_level", 32'(level), 0);

    // Stall on empty FIFO with req held.
    req = 1'b1;
    repeat (4) cyc();
    chk("stall_wv", 32'(word_valid), 0);
    for (int i = 0; i < 4; i++) begin
      push1(8'hA0 + 8'(i));
      if (i < 3) begin cyc(); cyc(); end
    end
    cyc();
    chk("early_wv", 32'(word_valid), 0);
    cyc();
    chk("late_wv", 32'(word_valid), 1);
    chk("word_stall", rand_word, 32'hA0A1A2A3);
    req = 1'b0;
    ack1();

    // Overflow and push coincident with a pop while full.
    for (int i = 0; i < 8; i++) push1(8'h10 + 8'(i));
    chk("full_level", 32'(level), 8);
    push1(8'hFF);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 8);
    req = 1'b1; cyc(); req = 1'b0;
    push1(8'h5C);
    chk("pushpop_level", 32'(level), 8);
    wait_wv(n);
    chk("ovf_word_wv", 32'(word_valid), 1);
    chk("ovf_word", rand_word, 32'h10111213);
    ack1();

    // Reset mid-gather.
    do_rst();
    push1(8'hB0); push1(8'hB1); push1(8'hB2); push1(8'hB3);
    req = 1'b1; cyc(); req = 1'b0;
    cyc(); cyc();
    do_rst();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_wv", 32'(word_valid), 0);
    repeat (8) cyc();
    chk("no_wv_after_rst", 32'(word_valid), 0);
    push1(8'hC0); push1(8'hC1); push1(8'hC2); push1(8'hC3);
    req = 1'b1; cyc(); req = 1'b0;
    wait_wv(n);
    chk("lat_after_rst", n, 5);
    chk("word_after_rst", rand_word, 32'hC0C1C2C3);
    ack1();

    // Repetition test.
    do_rst();
    repeat (4) push1(8'h5A);
    chk("rep_level", 32'(level), EXP39_L);
    chk("rep_hf", 32'(health_fail), EXP39_H);
    push1(8'h33);
    chk("rep_after_level", 32'(level), EXP39_L2);

    // enable=0 blocks pushes only.
    do_rst();
    push1(8'hD0); push1(8'hD1); push1(8'hD2); push1(8'hD3);
    req = 1'b1; cyc(); req = 1'b0;
    wait_wv(n);
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push1(8'(i));
    chk("dis_level", 32'(level), 0);
    chk("dis_ovf", 32'(overflow), 0);
    chk("dis_wv", 32'(word_valid), 1);
    chk("dis_word", rand_word, 32'hD0D1D2D3);
    ack1();
    chk("dis_ack_wv", 32'(word_valid), 0);
    enable = 1'b1;

    // Random traffic against the model.
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      byte_ready = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 9) != 0);
      rand_byte  = ($urandom_range(0, 3) == 0) ?
                   8'($urandom_range(0, 1)) : 8'($urandom);
      req        = ($urandom_range(0, 2) == 0);
      word_ack   = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
